// File: rtl/combone_router.sv
// combone_router: one registered stage of a 5-port bufferless deflection
// router (N, S, E, W network ports plus Local).
// Every valid network flit leaves on exactly one output one cycle later.
// It is routed productively, ejected to Local, or deflected to the lowest
// free network port. The Local injection flit is served last.
//
// Build option: define DEFLECT_AGE_EN to turn on age-based priority.
// With it, a deflected flit has its age (bits 8:6) incremented, saturating
// at 7. Without it, priority is fixed port order N, S, E, W, then Local, and
// the age bits pass through unchanged.
//
// Flit format: bit 9 valid, bits 8:6 age, bits 5:3 dest X, bits 2:0 dest Y.
// An all-zero flit is the idle/invalid flit.
module combone_router #(
    parameter int LOCAL_X = 3,
    parameter int LOCAL_Y = 3
) (
    input  logic       clksig,
    input  logic       rstsig,
    input  logic [9:0] nin,
    input  logic [9:0] sin,
    input  logic [9:0] ein,
    input  logic [9:0] win,
    input  logic [9:0] lin,
    output logic [9:0] nout,
    output logic [9:0] sout,
    output logic [9:0] eout,
    output logic [9:0] wout,
    output logic [9:0] lout,
    output logic       lack
);

`ifdef DEFLECT_AGE_EN
    localparam bit AGE_EN = 1'b1;
`else
    localparam bit AGE_EN = 1'b0;
`endif

    // Output port encoding, also used as the index into the output arrays.
    typedef enum logic [2:0] {
        PORT_N    = 3'd0,
        PORT_S    = 3'd1,
        PORT_E    = 3'd2,
        PORT_W    = 3'd3,
        PORT_L    = 3'd4,
        PORT_NONE = 3'd7
    } port_e;

    typedef struct packed {
        port_e port;
        logic  deflected;
    } grant_t;

    // Minimal-path port: resolve X first, then Y, else the flit is home.
    function automatic port_e productive_port(input logic [9:0] f);
        port_e p;
        if (int'(f[5:3]) > LOCAL_X)      p = PORT_E;
        else if (int'(f[5:3]) < LOCAL_X) p = PORT_W;
        else if (int'(f[2:0]) > LOCAL_Y) p = PORT_N;
        else if (int'(f[2:0]) < LOCAL_Y) p = PORT_S;
        else                             p = PORT_L;
        return p;
    endfunction

    // Sort key: older flits go first; with ageing disabled every flit ties
    // and port order alone decides.
    function automatic logic [2:0] prio_key(input logic [9:0] f);
        return AGE_EN ? f[8:6] : 3'd0;
    endfunction

    // Deflection penalty: bump the age so the flit wins more often later.
    function automatic logic [9:0] age_bump(input logic [9:0] f);
        logic [9:0] r;
        r = f;
        if (AGE_EN && f[8:6] != 3'b111) r[8:6] = f[8:6] + 3'd1;
        return r;
    endfunction

    // Productive port if free, otherwise the lowest free network port.
    // An eject candidate only ever asks for Local, so a network flit never
    // lands on Local unless it is ejecting.
    function automatic grant_t allocate(input logic [9:0] f, input logic [4:0] busy);
        grant_t g;
        port_e  p;
        p           = productive_port(f);
        g.port      = PORT_NONE;
        g.deflected = 1'b0;
        if (!busy[p]) begin
            g.port = p;
        end else begin
            g.deflected = 1'b1;
            if (!busy[PORT_N])      g.port = PORT_N;
            else if (!busy[PORT_S]) g.port = PORT_S;
            else if (!busy[PORT_E]) g.port = PORT_E;
            else if (!busy[PORT_W]) g.port = PORT_W;
        end
        return g;
    endfunction

    logic [9:0] flit_in [4];
    logic [1:0] rank    [4];
    logic [9:0] out_d   [5];
    logic [9:0] out_q   [5];
    logic [4:0] busy;
    grant_t     grant;
    logic       lack_d;
    logic       lack_q;

    assign flit_in[0] = nin;
    assign flit_in[1] = sin;
    assign flit_in[2] = ein;
    assign flit_in[3] = win;

    // Rank each network flit by how many valid flits outrank it (older, or
    // same age on an earlier port); valid flits get distinct ranks 0..3.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rank[i] = 2'd0;
            for (int j = 0; j < 4; j++) begin
                if (j != i && flit_in[j][9] &&
                    (prio_key(flit_in[j]) > prio_key(flit_in[i]) ||
                     (prio_key(flit_in[j]) == prio_key(flit_in[i]) && j < i)))
                    rank[i] = rank[i] + 2'd1;
            end
        end
    end

    // Sequential port allocation: network flits in rank order, then Local
    // injection if a network output is still free.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        busy   = '0;
        grant  = '{port: PORT_NONE, deflected: 1'b0};
        lack_d = 1'b0;
        for (int k = 0; k < 5; k++) out_d[k] = '0;

        // NOTE: blocking assignments are intended here; each allocation must
        // see the ports claimed by the flits allocated before it.
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 4; i++) begin
                if (flit_in[i][9] && rank[i] == 2'(p)) begin
                    grant = allocate(flit_in[i], busy);
                    if (grant.port != PORT_NONE) begin
                        busy[grant.port]  = 1'b1;
                        out_d[grant.port] = grant.deflected ? age_bump(flit_in[i])
                                                            : flit_in[i];
                    end
                end
            end
        end

        // Injection needs a free network output; it then follows the same
        // rules as any other flit (eject, productive, or deflect).
        if (lin[9] && busy[3:0] != 4'hF) begin
            grant = allocate(lin, busy);
            if (grant.port != PORT_NONE) begin
                busy[grant.port]  = 1'b1;
                out_d[grant.port] = grant.deflected ? age_bump(lin) : lin;
                lack_d            = 1'b1;
            end
        end
    end

    // Output register stage: one-cycle latency, cleared by synchronous reset.
    always_ff @(posedge clksig) begin
        // NOTE: the output registers are real state visible at the ports, so
        // they are all cleared on reset rather than left to the first flit.
        if (!rstsig) begin
            for (int k = 0; k < 5; k++) out_q[k] <= '0;
            lack_q <= 1'b0;
        end else begin
            for (int k = 0; k < 5; k++) out_q[k] <= out_d[k];
            lack_q <= lack_d;
        end
    end

    assign nout = out_q[PORT_N];
    assign sout = out_q[PORT_S];
    assign eout = out_q[PORT_E];
    assign wout = out_q[PORT_W];
    assign lout = out_q[PORT_L];
    assign lack = lack_q;

endmodule

// File: tb/tb_combone_router.sv
// Self-checking bench for combone_router placed at mesh position (2,2).
// Directed vectors from a table, a few multi-cycle sequences, then random
// traffic compared against a queue-based reference model.
module tb_combone_router;

    localparam int LX = 2;
    localparam int LY = 2;

`ifdef DEFLECT_AGE_EN
    localparam bit AGE_EN = 1'b1;
`else
    localparam bit AGE_EN = 1'b0;
`endif

    logic       clksig = 1'b0;
    logic       rstsig;
    logic [9:0] nin, sin, ein, win, lin;
    logic [9:0] nout, sout, eout, wout, lout;
    logic       lack;

    combone_router #(.LOCAL_X(LX), .LOCAL_Y(LY)) dut (
        .clksig(clksig),
        .rstsig(rstsig),
        .nin(nin),
        .sin(sin),
        .ein(ein),
        .win(win),
        .lin(lin),
        .nout(nout),
        .sout(sout),
        .eout(eout),
        .wout(wout),
        .lout(lout),
        .lack(lack)
    );

    always #5 clksig = ~clksig;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Index order everywhere: 0=N 1=S 2=E 3=W 4=L.
    typedef struct {
        string           name;
        logic [4:0][9:0] in;
        logic [4:0][9:0] out;
        logic            lk;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm,
                       input logic [9:0] n, input logic [9:0] s, input logic [9:0] e,
                       input logic [9:0] w, input logic [9:0] l,
                       input logic [9:0] on, input logic [9:0] os, input logic [9:0] oe,
                       input logic [9:0] ow, input logic [9:0] ol, input logic lk);
        vec_t v;
        v.name = nm;
        v.in   = {l, w, e, s, n};
        v.out  = {ol, ow, oe, os, on};
        v.lk   = lk;
        vecs.push_back(v);
    endtask

    // ---------------- reference model ----------------
    // Where a flit wants to go, from its destination coordinates.
    function automatic int target(input logic [9:0] f);
        int x, y;
        x = int'(f[5:3]);
        y = int'(f[2:0]);
        if (x > LX) return 2;
        if (x < LX) return 3;
        if (y > LY) return 0;
        if (y < LY) return 1;
        return 4;
    endfunction

    function automatic int choose(input logic [9:0] f, input bit [4:0] taken);
        int t;
        t = target(f);
        if (!taken[t]) return t;
        for (int q = 0; q < 4; q++) if (!taken[q]) return q;
        return -1;
    endfunction

    function automatic logic [9:0] emit(input logic [9:0] f, input bit deflected);
        logic [9:0] r;
        int         a;
        r = f;
        if (deflected && AGE_EN) begin
            a = int'(f[8:6]) + 1;
            if (a > 7) a = 7;
            r[8:6] = 3'(a);
        end
        return r;
    endfunction

    task automatic model(input logic [4:0][9:0] f, output logic [4:0][9:0] o, output logic lk);
        bit [4:0] taken;
        int       pending[$];
        int       best, idx, p;
        taken = '0;
        o     = '0;
        lk    = 1'b0;
        for (int i = 0; i < 4; i++) if (f[i][9]) pending.push_back(i);
        // Repeatedly serve the oldest remaining flit; earliest port wins ties.
        while (pending.size() > 0) begin
            best = 0;
            for (int k = 1; k < pending.size(); k++)
                if (AGE_EN && f[pending[k]][8:6] > f[pending[best]][8:6]) best = k;
            idx = pending[best];
            pending.delete(best);
            p = choose(f[idx], taken);
            if (p >= 0) begin
                taken[p] = 1'b1;
                o[p]     = emit(f[idx], p != target(f[idx]));
            end
        end
        if (f[4][9] && taken[3:0] != 4'hF) begin
            p = choose(f[4], taken);
            if (p >= 0) begin
                taken[p] = 1'b1;
                o[p]     = emit(f[4], p != target(f[4]));
                lk       = 1'b1;
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic drive(input logic [4:0][9:0] f);
        nin = f[0];
        sin = f[1];
        ein = f[2];
        win = f[3];
        lin = f[4];
    endtask

    task automatic check_all(input string tag, input logic [4:0][9:0] o, input logic lk);
        check({tag, ".nout"}, nout, o[0]);
        check({tag, ".sout"}, sout, o[1]);
        check({tag, ".eout"}, eout, o[2]);
        check({tag, ".wout"}, wout, o[3]);
        check({tag, ".lout"}, lout, o[4]);
        check({tag, ".lack"}, {9'd0, lack}, {9'd0, lk});
    endtask

    function automatic logic [9:0] rand_flit();
        logic [9:0] f;
        f[9]   = ($urandom % 4) != 0;
        f[8:6] = 3'($urandom % 8);
        f[5:3] = 3'($urandom % 5);
        f[2:0] = 3'($urandom % 5);
        if (!f[9]) f = '0;
        return f;
    endfunction

    logic [4:0][9:0] zero5;
    logic [4:0][9:0] stim;
    logic [4:0][9:0] exp_o;
    logic            exp_lk;

    initial begin
        zero5 = '0;

        add("route_e",     10'h22A, 10'h000, 10'h000, 10'h000, 10'h000,
                           10'h000, 10'h000, 10'h22A, 10'h000, 10'h000, 1'b0);
        add("eject",       10'h000, 10'h212, 10'h212, 10'h000, 10'h000,
                           AGE_EN ? 10'h252 : 10'h212, 10'h000, 10'h000, 10'h000, 10'h212, 1'b0);
        add("conflict",    10'h2EA, 10'h26A, 10'h000, 10'h000, 10'h000,
                           AGE_EN ? 10'h2AA : 10'h26A, 10'h000, 10'h2EA, 10'h000, 10'h000, 1'b0);
        add("inj_blocked", 10'h22A, 10'h22A, 10'h22A, 10'h22A, 10'h22A,
                           AGE_EN ? 10'h26A : 10'h22A, AGE_EN ? 10'h26A : 10'h22A, 10'h22A,
                           AGE_EN ? 10'h26A : 10'h22A, 10'h000, 1'b0);
        add("inj_ok",      10'h22A, 10'h000, 10'h000, 10'h000, 10'h22A,
                           AGE_EN ? 10'h26A : 10'h22A, 10'h000, 10'h22A, 10'h000, 10'h000, 1'b1);
        add("age_sat",     10'h3EA, 10'h3EA, 10'h000, 10'h000, 10'h000,
                           10'h3EA, 10'h000, 10'h3EA, 10'h000, 10'h000, 1'b0);
        add("idle",        10'h000, 10'h000, 10'h000, 10'h000, 10'h000,
                           10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 1'b0);
        add("route_n",     10'h000, 10'h000, 10'h000, 10'h213, 10'h000,
                           10'h213, 10'h000, 10'h000, 10'h000, 10'h000, 1'b0);
        add("route_s",     10'h000, 10'h000, 10'h211, 10'h000, 10'h000,
                           10'h000, 10'h211, 10'h000, 10'h000, 10'h000, 1'b0);
        add("lin_eject",   10'h000, 10'h000, 10'h000, 10'h000, 10'h212,
                           10'h000, 10'h000, 10'h000, 10'h000, 10'h212, 1'b1);
        add("lin_invalid", 10'h000, 10'h000, 10'h000, 10'h000, 10'h012,
                           10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 1'b0);
        add("age_prio",    10'h22A, 10'h000, 10'h000, 10'h36A, 10'h000,
                           AGE_EN ? 10'h26A : 10'h36A, 10'h000, AGE_EN ? 10'h36A : 10'h22A,
                           10'h000, 10'h000, 1'b0);

        // Reset with every input driven to all ones.
        rstsig = 1'b0;
        drive({5{10'h3FF}});
        @(posedge clksig);
        #1;
        check_all("reset", zero5, 1'b0);

        // Directed table.
        @(negedge clksig);
        rstsig = 1'b1;
        foreach (vecs[i]) begin
            if (i != 0) @(negedge clksig);
            drive(vecs[i].in);
            @(posedge clksig);
            #1;
            check_all(vecs[i].name, vecs[i].out, vecs[i].lk);
        end

        // Latency: nothing before the edge, flit after it, gone the next cycle.
        @(negedge clksig);
        drive(zero5);
        @(posedge clksig);
        @(negedge clksig);
        nin = 10'h22A;
        #1;
        check("lat_pre.eout", eout, 10'h000);
        @(posedge clksig);
        #1;
        check("lat_one.eout", eout, 10'h22A);
        @(negedge clksig);
        drive(zero5);
        @(posedge clksig);
        #1;
        check("lat_drain.eout", eout, 10'h000);

        // A refused injection is not held and replayed later.
        @(negedge clksig);
        drive({10'h22A, 10'h22A, 10'h22A, 10'h22A, 10'h22A});
        @(posedge clksig);
        #1;
        check("refuse.lack", {9'd0, lack}, 10'd0);
        @(negedge clksig);
        drive(zero5);
        @(posedge clksig);
        #1;
        check_all("refuse_drop", zero5, 1'b0);

        // Reset during traffic wins over the incoming flits.
        @(negedge clksig);
        drive({10'h212, 10'h000, 10'h000, 10'h000, 10'h22A});
        rstsig = 1'b0;
        @(posedge clksig);
        #1;
        check_all("reset_busy", zero5, 1'b0);
        @(negedge clksig);
        rstsig = 1'b1;

        // Random traffic against the reference model.
        for (int c = 0; c < 500; c++) begin
            if (c != 0) @(negedge clksig);
            for (int k = 0; k < 5; k++) stim[k] = rand_flit();
            drive(stim);
            model(stim, exp_o, exp_lk);
            @(posedge clksig);
            #1;
            check_all("rand", exp_o, exp_lk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
